// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the shared multi-cycle RV32I datapath (lw, sw, R/I ALU ops, beq, jal).
// Define MC_ILLEGAL_TRAP_EN to halt in a TRAP state on illegal instructions instead of treating them as NOPs.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_wren,
  output logic       addr_sel,
  output logic       ir_wren,
  output logic       pc_wren,
  output logic       regfile_wren,
  output logic [1:0] ALU_asel,
  output logic [1:0] ALU_bsel,
  output logic [1:0] result_sel,
  output logic [1:0] ximm_sel,
  output logic [2:0] ALU_control,
  output logic [3:0] state,
  output logic       trap
);

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECUTER = 4'd6;
  localparam logic [3:0] ST_EXECUTEI = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic [3:0] ST_TRAP     = 4'd11;
  localparam logic [3:0] ST_ILLEGAL  = ST_TRAP;
`else
  localparam logic [3:0] ST_ILLEGAL  = ST_FETCH;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ASEL_PC    = 2'b00;
  localparam logic [1:0] ASEL_OLDPC = 2'b01;
  localparam logic [1:0] ASEL_RS1   = 2'b10;
  localparam logic [1:0] BSEL_RS2   = 2'b00;
  localparam logic [1:0] BSEL_XIMM  = 2'b01;
  localparam logic [1:0] BSEL_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] XIMM_I     = 2'b00;
  localparam logic [1:0] XIMM_S     = 2'b01;
  localparam logic [1:0] XIMM_B     = 2'b10;
  localparam logic [1:0] XIMM_J     = 2'b11;

  logic [3:0] state_q, state_d;
  logic       alu_legal;
  logic [2:0] alu_op;
  logic       req_raw, wren_raw, ir_raw, pc_raw, rf_raw;

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Arithmetic decode shared by EXECUTER and EXECUTEI; funct7b5 only selects sub for R-type.
  always_comb begin
    alu_legal = 1'b1;
    alu_op    = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ximm_sel = XIMM_S;
      OP_BRANCH: ximm_sel = XIMM_B;
      OP_JAL:    ximm_sel = XIMM_J;
      default:   ximm_sel = XIMM_I;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? ST_MEMADR : ST_ILLEGAL;
          OP_RTYPE:          state_d = ST_EXECUTER;
          OP_ITYPE:          state_d = ST_EXECUTEI;
          OP_BRANCH:         state_d = (funct3 == 3'b000) ? ST_BEQ : ST_ILLEGAL;
          OP_JAL:            state_d = ST_JAL;
          default:           state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEMADR:   state_d = (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECUTER,
      ST_EXECUTEI: state_d = alu_legal ? ST_ALUWB : ST_ILLEGAL;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BEQ:      state_d = ST_FETCH;
      ST_JAL:      state_d = ST_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:     state_d = ST_TRAP;
`endif
      default:     state_d = ST_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    req_raw     = 1'b0;
    wren_raw    = 1'b0;
    addr_sel    = 1'b0;
    ir_raw      = 1'b0;
    pc_raw      = 1'b0;
    rf_raw      = 1'b0;
    ALU_asel    = ASEL_PC;
    ALU_bsel    = BSEL_RS2;
    result_sel  = RES_ALUOUT;
    ALU_control = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        req_raw    = 1'b1;
        ALU_bsel   = BSEL_FOUR;
        result_sel = RES_ALU;
        ir_raw     = mem_ready;
        pc_raw     = mem_ready;
      end
      ST_DECODE: begin
        ALU_asel = ASEL_OLDPC;
        ALU_bsel = BSEL_XIMM;
      end
      ST_MEMADR: begin
        ALU_asel = ASEL_RS1;
        ALU_bsel = BSEL_XIMM;
      end
      ST_MEMREAD: begin
        req_raw  = 1'b1;
        addr_sel = 1'b1;
      end
      ST_MEMWB: begin
        result_sel = RES_MDR;
        rf_raw     = 1'b1;
      end
      ST_MEMWRITE: begin
        req_raw  = 1'b1;
        wren_raw = 1'b1;
        addr_sel = 1'b1;
      end
      ST_EXECUTER: begin
        ALU_asel    = ASEL_RS1;
        ALU_control = alu_op;
      end
      ST_EXECUTEI: begin
        ALU_asel    = ASEL_RS1;
        ALU_bsel    = BSEL_XIMM;
        ALU_control = alu_op;
      end
      ST_ALUWB:    rf_raw = 1'b1;
      ST_BEQ: begin
        ALU_asel    = ASEL_RS1;
        ALU_control = ALU_SUB;
        pc_raw      = Z;
      end
      ST_JAL: begin
        ALU_asel = ASEL_OLDPC;
        ALU_bsel = BSEL_FOUR;
        pc_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked while reset is asserted so an abandoned access can never write.
  assign mem_req      = reset & req_raw;
  assign mem_wren     = reset & wren_raw;
  assign ir_wren      = reset & ir_raw;
  assign pc_wren      = reset & pc_raw;
  assign regfile_wren = reset & rf_raw;

`ifdef MC_ILLEGAL_TRAP_EN
  assign trap = reset & (state_q == ST_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction expected cycle traces
// are generated from the instruction class and compared against the DUT every cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Z, mem_ready;
  logic       mem_req, mem_wren, addr_sel, ir_wren, pc_wren, regfile_wren, trap;
  logic [1:0] ALU_asel, ALU_bsel, result_sel, ximm_sel;
  logic [2:0] ALU_control;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_wren(mem_wren), .addr_sel(addr_sel),
    .ir_wren(ir_wren), .pc_wren(pc_wren), .regfile_wren(regfile_wren), .ALU_asel(ALU_asel),
    .ALU_bsel(ALU_bsel), .result_sel(result_sel), .ximm_sel(ximm_sel),
    .ALU_control(ALU_control), .state(state), .trap(trap)
  );

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_e;

  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, asel_mem, ir, pc, rf;
    logic [1:0] a, b, res;
    logic [2:0] alu;
    logic       trap, rdy, z;
  } step_t;

  step_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_ximm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_alu(input kind_e k, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] obs_outs();
    return {14'b0, mem_req, mem_wren, addr_sel, ir_wren, pc_wren, regfile_wren,
            ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, trap};
  endfunction

  function automatic logic [31:0] exp_outs(input step_t s, input logic [6:0] o);
    return {14'b0, s.req, s.wr, s.asel_mem, s.ir, s.pc, s.rf,
            s.a, s.b, s.res, exp_ximm(o), s.alu, s.trap};
  endfunction

  function automatic logic [31:0] obs_enables();
    return {26'b0, mem_req, mem_wren, ir_wren, pc_wren, regfile_wren, trap};
  endfunction

  function automatic step_t blank(input logic [3:0] st);
    step_t s;
    s     = '0;
    s.st  = st;
    s.rdy = 1'($urandom);
    s.z   = 1'($urandom);
    return s;
  endfunction

  task automatic push_fetch(input int waits);
    step_t s;
    for (int i = 0; i <= waits; i++) begin
      s = blank(4'd0);
      s.req = 1'b1; s.b = 2'b10; s.res = 2'b10;
      s.rdy = (i == waits);
      s.ir  = s.rdy; s.pc = s.rdy;
      q.push_back(s);
    end
  endtask

  task automatic push_mem(input logic [3:0] st, input int waits, input logic wr);
    step_t s;
    for (int i = 0; i <= waits; i++) begin
      s = blank(st);
      s.req = 1'b1; s.asel_mem = 1'b1; s.wr = wr;
      s.rdy = (i == waits);
      q.push_back(s);
    end
  endtask

  // Expected per-cycle trace of one instruction, from fetch to its last cycle.
  task automatic build(input kind_e k, input logic [2:0] f3, input logic f7,
                       input int wf, input int wm, input int zf);
    step_t s;
    q.delete();
    push_fetch(wf);
    s = blank(4'd1); s.a = 2'b01; s.b = 2'b01; q.push_back(s);
    case (k)
      K_LW, K_SW: begin
        s = blank(4'd2); s.a = 2'b10; s.b = 2'b01; q.push_back(s);
        if (k == K_LW) begin
          push_mem(4'd3, wm, 1'b0);
          s = blank(4'd4); s.res = 2'b01; s.rf = 1'b1; q.push_back(s);
        end else begin
          push_mem(4'd5, wm, 1'b1);
        end
      end
      K_R, K_I: begin
        s = blank(k == K_R ? 4'd6 : 4'd7);
        s.a = 2'b10; s.b = (k == K_R) ? 2'b00 : 2'b01; s.alu = exp_alu(k, f3, f7);
        q.push_back(s);
        s = blank(4'd8); s.rf = 1'b1; q.push_back(s);
      end
      K_BEQ: begin
        s = blank(4'd9); s.a = 2'b10; s.alu = 3'b001;
        if (zf >= 0) s.z = zf[0];
        s.pc = s.z;
        q.push_back(s);
      end
      K_JAL: begin
        s = blank(4'd10); s.a = 2'b01; s.b = 2'b10; s.pc = 1'b1; q.push_back(s);
        s = blank(4'd8); s.rf = 1'b1; q.push_back(s);
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
          s = blank(4'd11); s.trap = 1'b1; q.push_back(s);
        end
`endif
      end
    endcase
  endtask

  // Called at posedge+1; drives each step, samples at the falling edge.
  task automatic play(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int limit);
    step_t s;
    for (int i = 0; i < q.size() && i < limit; i++) begin
      s = q[i];
      op = o; funct3 = f3; funct7b5 = f7;
      mem_ready = s.rdy; Z = s.z;
      @(negedge clk);
      check($sformatf("state_op%b_c%0d", o, i), 32'(state), 32'(s.st));
      check($sformatf("outs_op%b_st%0d", o, s.st), obs_outs(), exp_outs(s, o));
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_pulse(input int cycles);
    reset = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_enables", obs_enables(), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      mem_ready = 1'($urandom); Z = 1'($urandom);
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_enables", obs_enables(), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  task automatic run(input kind_e k, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input int wf, input int wm, input int zf);
    build(k, f3, f7, wf, wm, zf);
    play(o, f3, f7, q.size());
`ifdef MC_ILLEGAL_TRAP_EN
    if (k == K_ILL) reset_pulse(2);
`endif
  endtask

  task automatic run_random();
    logic [2:0] f3s [4];
    logic [6:0] ills [4];
    logic [2:0] ill_f3 [4];
    kind_e k;
    int    j;
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    f3s    = '{3'b000, 3'b111, 3'b110, 3'b010};
    ills   = '{7'b1111111, 7'b0110111, 7'b0000011, 7'b1100011};
    ill_f3 = '{3'b010, 3'b000, 3'b000, 3'b001};
    k  = kind_e'($urandom_range(0, 6));
    f7 = 1'($urandom);
    f3 = 3'($urandom);
    case (k)
      K_LW:  begin o = 7'b0000011; f3 = 3'b010; end
      K_SW:  begin o = 7'b0100011; f3 = 3'b010; end
      K_R:   begin o = 7'b0110011; f3 = f3s[$urandom_range(0, 3)]; end
      K_I:   begin o = 7'b0010011; f3 = f3s[$urandom_range(0, 3)]; end
      K_BEQ: begin o = 7'b1100011; f3 = 3'b000; end
      K_JAL: o = 7'b1101111;
      default: begin
        j = $urandom_range(0, 3);
        o = ills[j]; f3 = ill_f3[j];
      end
    endcase
    run(k, o, f3, f7, $urandom_range(0, 2), $urandom_range(0, 3), -1);
  endtask

  initial begin
    reset = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Z = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("init_rst_state", 32'(state), 32'd0);
      check("init_rst_enables", obs_enables(), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;

    run(K_R,   7'b0110011, 3'b000, 1'b0, 0, 0, -1);
    run(K_R,   7'b0110011, 3'b000, 1'b1, 0, 0, -1);
    run(K_I,   7'b0010011, 3'b000, 1'b1, 1, 0, -1);
    run(K_LW,  7'b0000011, 3'b010, 1'b0, 0, 2, -1);
    run(K_SW,  7'b0100011, 3'b010, 1'b0, 0, 1, -1);
    run(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 1);
    run(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 0);
    run(K_JAL, 7'b1101111, 3'b101, 1'b0, 0, 0, -1);
    run(K_ILL, 7'b1111111, 3'b000, 1'b0, 0, 0, -1);

    // lw abandoned by reset while MEMREAD is waiting on memory
    build(K_LW, 3'b010, 1'b0, 0, 3, -1);
    play(7'b0000011, 3'b010, 1'b0, 4);
    reset_pulse(2);

    repeat (150) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
